pixie_dma_responder: RTL and testbench

PIXIE_DMA_RESPONDER -- requirements
Module: pixie_dma_responder

---
 rtl/pixie_dma_responder.sv | 145 ++++++++++++++
 tb/tb_pixie_dma_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixie_dma_responder.sv
// pixie_dma_responder
//   DMA-out responder for an 1861-style video chip. When the chip requests a
//   byte (dma_out_req) and the CPU offers a machine cycle (ce), the block
//   stalls the CPU, reads the byte at R0, hands it to the video chip and
//   advances R0. A read that never returns is forced to complete with 8'h00
//   after TIMEOUT wait cycles, and the sticky err flag records it.
//
// Ports
//   clk_sys      system clock (rising edge)
//   resetq       asynchronous active-low reset
//   ce           CPU machine-cycle enable; grants only happen on ce=1
//   dma_out_req  DMAO request level from the video chip
//   r0_load      CPU strobe writing R0 (honoured only in IDLE)
//   r0_din       new R0 value
//   r0_q         current R0 / DMA pointer
//   cpu_hold     high while a DMA cycle is in progress
//   mem_rd       one-cycle read strobe, address mem_addr (= r0_q)
//   mem_q        read data, qualified by mem_valid
//   pix_data     byte delivered to the video chip (held between strobes)
//   pix_wr       one-cycle strobe qualifying pix_data
//   line_done    pulses with the 8th byte of a line
//   err          sticky: at least one read timed out (cleared by r0_load)
module pixie_dma_responder #(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [15:0] R0_RESET = 16'h0900
) (
  input  logic        clk_sys,
  input  logic        resetq,
  input  logic        ce,
  input  logic        dma_out_req,
  input  logic        r0_load,
  input  logic [15:0] r0_din,
  output logic [15:0] r0_q,
  output logic        cpu_hold,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_q,
  input  logic        mem_valid,
  output logic [7:0]  pix_data,
  output logic        pix_wr,
  output logic        line_done,
  output logic        err
);

  // Counter holds completed WAIT cycles, 0 .. TIMEOUT-1.
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  wait_cnt;
  logic [2:0]     byte_cnt;
  logic           wait_last;

  assign mem_addr = r0_q;

  // True in the TIMEOUT-th WAIT cycle; mem_valid in the same cycle still wins.
  assign wait_last = (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_sys or negedge resetq) begin
    if (!resetq) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cpu_hold  = 1'b0;
    mem_rd    = 1'b0;
    pix_wr    = 1'b0;
    line_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (ce && dma_out_req && !r0_load) begin
          state_nxt = READ;
        end
      end
      READ: begin
        cpu_hold  = 1'b1;
        mem_rd    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        cpu_hold = 1'b1;
        if (mem_valid || wait_last) begin
          state_nxt = DELIVER;
        end
      end
      DELIVER: begin
        cpu_hold  = 1'b1;
        pix_wr    = 1'b1;
        line_done = (byte_cnt == 3'd7);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge resetq) begin
    if (!resetq) begin
      r0_q     <= R0_RESET;
      byte_cnt <= '0;
      wait_cnt <= '0;
      err      <= 1'b0;
      pix_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (r0_load) begin
            r0_q     <= r0_din;
            byte_cnt <= '0;
            err      <= 1'b0;
          end
        end
        READ: begin
          wait_cnt <= '0;
        end
        WAIT: begin
          if (mem_valid) begin
            pix_data <= mem_q;
          end else if (wait_last) begin
            pix_data <= 8'h00;
            err      <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DELIVER: begin
          r0_q     <= r0_q + 16'd1;
          byte_cnt <= byte_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixie_dma_responder.sv
module tb_pixie_dma_responder;

  localparam int unsigned TO    = 15;
  localparam logic [15:0] R0RST = 16'h0900;

  logic        clk_sys;
  logic        resetq;
  logic        ce;
  logic        dma_out_req;
  logic        r0_load;
  logic [15:0] r0_din;
  logic [15:0] r0_q;
  logic        cpu_hold;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_q;
  logic        mem_valid;
  logic [7:0]  pix_data;
  logic        pix_wr;
  logic        line_done;
  logic        err;

  int total = 0;
  int bad   = 0;

  // Reference model: pointer, position within the line, sticky error, last byte.
  logic [15:0] exp_r0;
  int unsigned exp_pos;
  logic        exp_err;
  logic [7:0]  exp_pix;

  pixie_dma_responder #(.TIMEOUT(TO), .R0_RESET(R0RST)) dut (
    .clk_sys     (clk_sys),
    .resetq      (resetq),
    .ce          (ce),
    .dma_out_req (dma_out_req),
    .r0_load     (r0_load),
    .r0_din      (r0_din),
    .r0_q        (r0_q),
    .cpu_hold    (cpu_hold),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_q       (mem_q),
    .mem_valid   (mem_valid),
    .pix_data    (pix_data),
    .pix_wr      (pix_wr),
    .line_done   (line_done),
    .err         (err)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check_idle(input string tag);
    total++;
    if ({cpu_hold, mem_rd, pix_wr, line_done} !== 4'b0000) begin
      bad++;
      $display("FAIL %s idle strobes: got %b expected 0000", tag, {cpu_hold, mem_rd, pix_wr, line_done});
    end
    total++;
    if (r0_q !== exp_r0) begin
      bad++;
      $display("FAIL %s r0_q: got %h expected %h", tag, r0_q, exp_r0);
    end
    total++;
    if (err !== exp_err) begin
      bad++;
      $display("FAIL %s err: got %b expected %b", tag, err, exp_err);
    end
    total++;
    if (pix_data !== exp_pix) begin
      bad++;
      $display("FAIL %s pix_data hold: got %h expected %h", tag, pix_data, exp_pix);
    end
  endtask

  task automatic load_r0(input logic [15:0] v);
    @(negedge clk_sys);
    r0_load = 1'b1;
    r0_din  = v;
    ce      = 1'($urandom_range(0, 1));
    @(negedge clk_sys);
    r0_load = 1'b0;
    ce      = 1'b0;
    exp_r0  = v;
    exp_pos = 0;
    exp_err = 1'b0;
    check_idle("load_r0");
  endtask

  // One DMA byte. lat = WAIT cycle (1..TO) in which mem_valid is given, 0 = never.
  task automatic run_byte(input int unsigned lat, input logic [7:0] d);
    int unsigned w;
    int unsigned exp_w;
    logic [7:0]  exp_d;
    logic        seen;
    exp_w = (lat == 0) ? TO : lat;
    exp_d = (lat == 0) ? 8'h00 : d;
    @(negedge clk_sys);
    ce = 1'b1; dma_out_req = 1'b1; r0_load = 1'b0; mem_valid = 1'b0;
    @(negedge clk_sys);
    // READ cycle: the request may drop and junk valid is ignored.
    total++;
    if ({cpu_hold, mem_rd, pix_wr} !== 3'b110) begin
      bad++;
      $display("FAIL read strobes: got %b expected 110", {cpu_hold, mem_rd, pix_wr});
    end
    total++;
    if (mem_addr !== exp_r0) begin
      bad++;
      $display("FAIL read addr: got %h expected %h", mem_addr, exp_r0);
    end
    ce          = 1'b0;
    dma_out_req = 1'($urandom_range(0, 1));
    r0_load     = 1'($urandom_range(0, 1));
    r0_din      = 16'($urandom);
    mem_valid   = 1'($urandom_range(0, 1));
    mem_q       = 8'($urandom);
    w = 0;
    seen = 1'b0;
    for (int i = 0; i < int'(TO) + 4; i++) begin
      @(negedge clk_sys);
      if (pix_wr) begin
        seen = 1'b1;
        break;
      end
      w++;
      total++;
      if ({cpu_hold, mem_rd} !== 2'b10) begin
        bad++;
        $display("FAIL wait strobes: got %b expected 10", {cpu_hold, mem_rd});
      end
      mem_valid = (w == lat);
      mem_q     = (w == lat) ? d : 8'($urandom);
    end
    mem_valid = 1'b0;
    r0_load   = 1'b0;
    dma_out_req = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL deliver timeout: got no pix_wr expected one within %0d cycles", TO + 4);
    end
    total++;
    if (w !== exp_w) begin
      bad++;
      $display("FAIL wait length: got %0d expected %0d", w, exp_w);
    end
    total++;
    if (pix_data !== exp_d || cpu_hold !== 1'b1) begin
      bad++;
      $display("FAIL deliver data: got %h hold %b expected %h hold 1", pix_data, cpu_hold, exp_d);
    end
    total++;
    if (line_done !== (exp_pos == 7)) begin
      bad++;
      $display("FAIL line_done: got %b expected %b", line_done, exp_pos == 7);
    end
    exp_r0  = exp_r0 + 16'd1;
    exp_pos = (exp_pos + 1) % 8;
    exp_err = exp_err | (lat == 0);
    exp_pix = exp_d;
    @(negedge clk_sys);
    check_idle("after byte");
  endtask

  task automatic test_reset;
    resetq = 1'b0; ce = 1'b0; dma_out_req = 1'b1; r0_load = 1'b0;
    r0_din = '0; mem_q = '0; mem_valid = 1'b0;
    exp_r0 = R0RST; exp_pos = 0; exp_err = 1'b0; exp_pix = 8'h00;
    #12;
    check_idle("reset");
    @(negedge clk_sys);
    resetq = 1'b1;
    // Request held high, but no ce: nothing must start.
    repeat (3) @(negedge clk_sys);
    check_idle("post reset no ce");
    dma_out_req = 1'b0;
  endtask

  task automatic test_single;
    run_byte(1, 8'hA5);
  endtask

  task automatic test_line;
    load_r0(16'h0900);
    for (int i = 0; i < 8; i++) begin
      run_byte($urandom_range(1, TO), 8'(8'h10 + i));
    end
    total++;
    if (r0_q !== 16'h0908) begin
      bad++;
      $display("FAIL line end r0: got %h expected 0908", r0_q);
    end
  endtask

  task automatic test_timeout;
    run_byte(0, 8'hFF);
    load_r0(16'h1234);
  endtask

  task automatic test_simultaneous;
    run_byte(TO, 8'h5C);
  endtask

  task automatic test_wrap_collision;
    @(negedge clk_sys);
    r0_load = 1'b1; r0_din = 16'hFFFF; ce = 1'b1; dma_out_req = 1'b1;
    @(negedge clk_sys);
    r0_load = 1'b0; ce = 1'b0; dma_out_req = 1'b0;
    exp_r0 = 16'hFFFF; exp_pos = 0; exp_err = 1'b0;
    check_idle("collision");
    run_byte(2, 8'h3E);
    total++;
    if (r0_q !== 16'h0000) begin
      bad++;
      $display("FAIL wrap r0: got %h expected 0000", r0_q);
    end
  endtask

  task automatic test_back_to_back;
    run_byte(1, 8'h77);
    dma_out_req = 1'b1;
    ce = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_idle("b2b no ce");
    run_byte(1, 8'h78);
  endtask

  task automatic test_reset_mid_wait;
    @(negedge clk_sys);
    ce = 1'b1; dma_out_req = 1'b1;
    @(negedge clk_sys);
    ce = 1'b0; dma_out_req = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    resetq = 1'b0;
    #1;
    exp_r0 = R0RST; exp_pos = 0; exp_err = 1'b0; exp_pix = 8'h00;
    check_idle("reset mid wait");
    mem_valid = 1'b1; mem_q = 8'hC3;
    @(negedge clk_sys);
    resetq = 1'b1;
    mem_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      total++;
      if (pix_wr !== 1'b0 || cpu_hold !== 1'b0) begin
        bad++;
        $display("FAIL post reset activity: got pix_wr %b hold %b expected 0 0", pix_wr, cpu_hold);
      end
    end
    check_idle("after reset release");
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        run_byte(0, 8'($urandom));
      end else begin
        run_byte($urandom_range(1, TO), 8'($urandom));
      end
      if ($urandom_range(0, 9) == 0) begin
        load_r0(16'($urandom));
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_line;
    test_timeout;
    test_simultaneous;
    test_wrap_collision;
    test_back_to_back;
    test_reset_mid_wait;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global watchdog: got no finish expected finish before 500000");
    $fatal(1);
  end

endmodule
